// File: rtl/lsu_access_seq.sv
// Load/store sequencer in front of a word-wide synchronous-read memory.
// Sub-word stores use read-modify-write; accesses that cross a word boundary touch two words.
module lsu_access_seq #(
    parameter int MEM_DEPTH = 4,
    localparam int AW = $clog2(MEM_DEPTH) + 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [31:0]   req_wdata_i,
    input  logic [2:0]    req_strb_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_split_o,
    output logic [AW-1:0] mem_rd_addr_o,
    input  logic [31:0]   mem_rd_data_i,
    output logic [AW-1:0] mem_wr_addr_o,
    output logic [31:0]   mem_wr_data_o,
    output logic          mem_we_o,
    output logic [2:0]    dbg_state_o
);

    // Request handshake: a request transfers on a rising edge where req_valid_i and
    // req_ready_o are both high; a response transfers where rsp_valid_o and rsp_ready_i are.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_LO   = 3'd1,
        S_RD_HI   = 3'd2,
        S_RD_WAIT = 3'd3,
        S_WR_LO   = 3'd4,
        S_WR_HI   = 3'd5,
        S_RESP    = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    strb_q;
    logic [31:0]   buf_lo_q, buf_hi_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_split_q;

    logic [1:0]    off;
    logic [4:0]    shamt;
    logic [2:0]    nbytes;
    logic          split;
    logic [AW-1:0] lo_addr, hi_addr;
    logic [7:0]    byte_mask;
    logic [31:0]   wdata_m;
    logic [63:0]   sdata;
    logic [63:0]   window;
    logic [63:0]   merged;
    logic [31:0]   raw;
    logic [31:0]   load_data;
    logic          aligned_wstore_in;

    assign off     = addr_q[1:0];
    assign shamt   = {off, 3'b000};
    assign split   = (({1'b0, off}) + nbytes) > 3'd4;
    assign lo_addr = {addr_q[AW-1:2], 2'b00};
    assign hi_addr = lo_addr + AW'(4);

    assign aligned_wstore_in = req_we_i && req_strb_i[1] && (req_addr_i[1:0] == 2'b00);

    always_comb begin
        nbytes    = 3'd4;
        byte_mask = 8'h0F;
        wdata_m   = wdata_q;
        case (strb_q[1:0])
            2'b00: begin
                nbytes    = 3'd1;
                byte_mask = 8'h01;
                wdata_m   = {24'b0, wdata_q[7:0]};
            end
            2'b01: begin
                nbytes    = 3'd2;
                byte_mask = 8'h03;
                wdata_m   = {16'b0, wdata_q[15:0]};
            end
            default: ;
        endcase
        byte_mask = byte_mask << off;
        sdata     = {32'b0, wdata_m} << shamt;
    end

    // While the last read word is on the bus it is folded into the window directly, so
    // the load result can be registered on the same edge the buffers capture it.
    always_comb begin
        window = {buf_hi_q, buf_lo_q};
        if (state_q == S_RD_WAIT) begin
            window = split ? {mem_rd_data_i, buf_lo_q} : {32'b0, mem_rd_data_i};
        end
    end

    always_comb begin
        merged = window;
        for (int i = 0; i < 8; i++) begin
            if (byte_mask[i]) merged[8*i +: 8] = sdata[8*i +: 8];
        end
    end

    always_comb begin
        raw       = 32'(window >> shamt);
        load_data = raw;
        case (strb_q[1:0])
            2'b00:   load_data = {{24{raw[7] & ~strb_q[2]}}, raw[7:0]};
            2'b01:   load_data = {{16{raw[15] & ~strb_q[2]}}, raw[15:0]};
            default: load_data = raw;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req_valid_i) state_d = aligned_wstore_in ? S_WR_LO : S_RD_LO;
            S_RD_LO:   state_d = split ? S_RD_HI : S_RD_WAIT;
            S_RD_HI:   state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = we_q ? S_WR_LO : S_RESP;
            S_WR_LO:   state_d = split ? S_WR_HI : S_RESP;
            S_WR_HI:   state_d = S_RESP;
            S_RESP:    if (rsp_ready_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o   = 1'b0;
        rsp_valid_o   = 1'b0;
        mem_rd_addr_o = '0;
        mem_wr_addr_o = '0;
        mem_wr_data_o = '0;
        mem_we_o      = 1'b0;
        case (state_q)
            S_IDLE:  req_ready_o = 1'b1;
            S_RD_LO: mem_rd_addr_o = lo_addr;
            S_RD_HI: mem_rd_addr_o = hi_addr;
            S_WR_LO: begin
                mem_we_o      = 1'b1;
                mem_wr_addr_o = lo_addr;
                mem_wr_data_o = merged[31:0];
            end
            S_WR_HI: begin
                mem_we_o      = 1'b1;
                mem_wr_addr_o = hi_addr;
                mem_wr_data_o = merged[63:32];
            end
            S_RESP:  rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            buf_lo_q    <= '0;
            buf_hi_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_split_q <= 1'b0;
        end else begin
            if (req_valid_i && req_ready_o) begin
                we_q    <= req_we_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                strb_q  <= req_strb_i;
            end
            if (state_q == S_RD_HI) buf_lo_q <= mem_rd_data_i;
            if (state_q == S_RD_WAIT) begin
                if (split) begin
                    buf_hi_q <= mem_rd_data_i;
                end else begin
                    buf_lo_q <= mem_rd_data_i;
                    buf_hi_q <= '0;
                end
            end
            if (state_q != S_RESP && state_d == S_RESP) begin
                rsp_rdata_q <= we_q ? 32'b0 : load_data;
                rsp_split_q <= split;
            end
        end
    end

    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_split_o = rsp_split_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_access_seq.sv
// Scoreboard bench for lsu_access_seq: a byte-array reference model predicts load data,
// latency and write count; a negedge monitor checks every response against it.
module tb_lsu_access_seq;

    localparam int MEM_DEPTH = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [2:0]    req_strb;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_split;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data;
    logic [AW-1:0] mem_wr_addr;
    logic [31:0]   mem_wr_data;
    logic          mem_we;
    logic [2:0]    dbg_state;

    lsu_access_seq #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_split_o(rsp_split), .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_data),
        .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data), .mem_we_o(mem_we),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory array, reference bytes and scoreboard state
    logic [31:0]   mem_words [MEM_DEPTH];
    logic [31:0]   load_words [MEM_DEPTH];
    logic          load_en = 1'b0;
    logic [7:0]    ref_mem [4*MEM_DEPTH];
    logic [37:0]   exp_q[$];
    logic [AW-1:0] wr_log[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    bit            stall_req = 1'b0;

    always @(posedge clk) begin
        mem_rd_data <= mem_words[mem_rd_addr[AW-1:2]];
        if (load_en) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_words[i] <= load_words[i];
        end else if (mem_we) begin
            mem_words[mem_wr_addr[AW-1:2]] <= mem_wr_data;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer: random backpressure, or five held-off cycles when a stall is requested.
    initial begin
        int stall_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_valid && stall_req && stall_cnt < 5) begin
                rsp_ready = 1'b0;
                stall_cnt++;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
            if (!stall_req) stall_cnt = 0;
        end
    end

    // Monitor: compares each presented response against the head of the expected queue.
    initial begin
        int acc_cyc = 0;
        int nwr = 0;
        bit seen = 1'b0;
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req_valid && req_ready) begin
                    acc_cyc = cyc;
                    nwr = 0;
                    seen = 1'b0;
                end
                if (mem_we) begin
                    nwr++;
                    wr_log.push_back(mem_wr_addr);
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                    end else begin
                        e = exp_q[0];
                        if (!seen) begin
                            seen = 1'b1;
                            chk("latency", 64'(cyc - acc_cyc), 64'(e[35:33]));
                            chk("mem_we_cycles", 64'(nwr), 64'(e[37:36]));
                        end
                        chk("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
                        chk("rsp_split", 64'(rsp_split), 64'(e[32]));
                        chk("req_ready_in_resp", 64'(req_ready), 64'd0);
                        if (rsp_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    function automatic int size_bytes(input logic [2:0] strb);
        return (strb[1:0] == 2'b00) ? 1 : (strb[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    task automatic preload(input logic [31:0] w0, input logic [31:0] w1);
        load_words[0] = w0;
        load_words[1] = w1;
        load_words[2] = $urandom;
        load_words[3] = $urandom;
        for (int w = 0; w < MEM_DEPTH; w++) begin
            for (int b = 0; b < 4; b++) ref_mem[4*w+b] = load_words[w][8*b +: 8];
        end
        @(posedge clk);
        #1 load_en = 1'b1;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    task automatic check_mem(input string name);
        for (int w = 0; w < MEM_DEPTH; w++) chk(name, 64'(mem_words[w]), 64'(ref_word(w)));
    endtask

    task automatic do_access(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                             input logic [2:0] strb);
        int nb, lat, nwr;
        bit sp, ok;
        logic [31:0] rd;
        nb = size_bytes(strb);
        sp = (int'(addr[1:0]) + nb) > 4;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        rd = 32'b0;
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[4'(addr + 4'(i))] = wdata[8*i +: 8];
            lat = (nb == 4 && addr[1:0] == 2'b00) ? 2 : (sp ? 6 : 4);
            nwr = sp ? 2 : 1;
        end else begin
            for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_mem[4'(addr + 4'(i))];
            if (!strb[2] && nb == 1 && rd[7])  rd = rd | 32'hFFFF_FF00;
            if (!strb[2] && nb == 2 && rd[15]) rd = rd | 32'hFFFF_0000;
            lat = sp ? 4 : 3;
            nwr = 0;
        end
        exp_q.push_back({2'(nwr), 3'(lat), sp, rd});
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        chk("rsp_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_split", 64'(rsp_split), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
        chk("rst_mem_wr_addr", 64'(mem_wr_addr), 64'd0);
        chk("rst_mem_wr_data", 64'(mem_wr_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        preload(32'h4433_2211, 32'h8877_6655);
        do_access(1'b0, 4'h4, 32'h0, 3'b010);      // lw 0x4
        do_access(1'b0, 4'h2, 32'h0, 3'b010);      // lw 0x2, split
        do_access(1'b0, 4'h7, 32'h0, 3'b000);      // lb 0x7
        do_access(1'b0, 4'h7, 32'h0, 3'b100);      // lbu 0x7
        do_access(1'b0, 4'h3, 32'h0, 3'b001);      // lh 0x3, split
        do_access(1'b0, 4'h6, 32'h0, 3'b101);      // lhu 0x6
        do_access(1'b0, 4'h1, 32'h0, 3'b110);      // word load ignores unsigned bit
        do_access(1'b1, 4'h1, 32'h1234_56EF, 3'b000);
        chk("sb_word0", 64'(mem_words[0]), 64'h4433_EF11);
        do_access(1'b1, 4'h8, 32'hDEAD_BEEF, 3'b010);
        chk("sw_word2", 64'(mem_words[2]), 64'hDEAD_BEEF);

        preload(32'h4433_2211, 32'h8877_6655);
        wr_log.delete();
        do_access(1'b1, 4'h3, 32'h0000_ABCD, 3'b001);
        chk("sh_split_word0", 64'(mem_words[0]), 64'hCD33_2211);
        chk("sh_split_word1", 64'(mem_words[1]), 64'h8877_66AB);
        chk("sh_split_nwr", 64'(wr_log.size()), 64'd2);
        if (wr_log.size() == 2) begin
            chk("sh_split_lo_addr", 64'(wr_log[0]), 64'h0);
            chk("sh_split_hi_addr", 64'(wr_log[1]), 64'h4);
        end

        wr_log.delete();
        do_access(1'b1, 4'hF, 32'h0000_BEEF, 3'b001);
        chk("wrap_byte_f", 64'(mem_words[3][31:24]), 64'hEF);
        chk("wrap_byte_0", 64'(mem_words[0][7:0]), 64'hBE);
        if (wr_log.size() == 2) chk("wrap_hi_addr", 64'(wr_log[1]), 64'h0);
        else chk("wrap_nwr", 64'(wr_log.size()), 64'd2);
        check_mem("mem_after_directed");

        stall_req = 1'b1;
        do_access(1'b0, 4'h5, 32'h0, 3'b001);      // monitor checks stability each held cycle
        stall_req = 1'b0;

        // Reset during the second write of a split store
        preload(32'h4433_2211, 32'h8877_6655);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'h3;
        req_wdata = 32'h0000_ABCD;
        req_strb  = 3'b001;
        @(negedge clk);
        chk("rst_test_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("wr_hi_we", 64'(mem_we), 64'd1);
        chk("wr_hi_addr", 64'(mem_wr_addr), 64'h4);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_we", 64'(mem_we), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ref_mem[3] = 8'hCD;
        repeat (3) @(negedge clk);
        chk("midrst_word1", 64'(mem_words[1]), 64'h8877_6655);
        check_mem("mem_after_midrst");

        for (int n = 0; n < 60; n++) begin
            do_access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                      3'($urandom_range(0, 7)));
        end
        check_mem("mem_after_random");

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
